// File: rtl/tt_um_jleugeri_ttt_event_router_if.sv
// Connection-table write bus for the TTT event router.
// The master drives one table entry per cfg_we strobe; the router is the slave.
interface tt_um_jleugeri_ttt_event_router_if #(
    parameter int IDX_BITS = 4
) ();
    logic                cfg_we;
    logic [IDX_BITS-1:0] cfg_src;
    logic [IDX_BITS-1:0] cfg_first;
    logic [IDX_BITS-1:0] cfg_last;
    logic                cfg_bad;

    modport master (
        output cfg_we,
        output cfg_src,
        output cfg_first,
        output cfg_last,
        output cfg_bad
    );

    modport slave (
        input cfg_we,
        input cfg_src,
        input cfg_first,
        input cfg_last,
        input cfg_bad
    );
endinterface

// File: rtl/tt_um_jleugeri_ttt_event_router.sv
// TTT event router: latches start/stop events from NUM_PROCESSORS token
// processors, and on each go scans every source and adds its signed net
// event (+1 start, -1 stop) into a programmable contiguous range of target
// accumulators (good or bad). done pulses once the accumulators are final.
// Optional build macro TTT_ROUTER_SATURATE_EN: clamp on overflow and raise
// sat_flag_o; without it the accumulators wrap and sat_flag_o is 0.
module tt_um_jleugeri_ttt_event_router #(
    parameter int NUM_PROCESSORS  = 10,
    parameter int NEW_TOKENS_BITS = 4,
    parameter int IDX_BITS        = $clog2(NUM_PROCESSORS)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [2*NUM_PROCESSORS-1:0]               tstartstop_i,
    input  logic                                      go_i,
    tt_um_jleugeri_ttt_event_router_if.slave          cfg,
    output logic [NUM_PROCESSORS*NEW_TOKENS_BITS-1:0] new_good_tokens_o,
    output logic [NUM_PROCESSORS*NEW_TOKENS_BITS-1:0] new_bad_tokens_o,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      sat_flag_o
);
    localparam int N = NUM_PROCESSORS;
    localparam int W = NEW_TOKENS_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N - 1);
    localparam logic [IDX_BITS:0]   N_EXT    = (IDX_BITS + 1)'(N);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_DELIVER = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] src_q, src_d;
    logic [IDX_BITS-1:0] tgt_q, tgt_d;

    logic [N-1:0] pend_start_q, pend_stop_q;
    logic [N-1:0] snap_start_q, snap_stop_q;
    logic [N-1:0] ev_start, ev_stop;

    logic [N-1:0]        tbl_valid_q;
    logic [N-1:0]        tbl_bad_q;
    logic [IDX_BITS-1:0] tbl_first_q [N];
    logic [IDX_BITS-1:0] tbl_last_q  [N];

    logic signed [W-1:0] acc_good_q [N];
    logic signed [W-1:0] acc_bad_q  [N];

    logic                start_round;
    logic                cfg_accept;
    logic                cfg_entry_ok;
    logic                deliver_en;
    logic                cur_start, cur_stop, cur_valid, cur_bad;
    logic [IDX_BITS-1:0] cur_first, cur_last;
    logic                net_nz;
    logic signed [W-1:0] net_val;

    // Split the interleaved start/stop pulse bus per source.
    for (genvar gi = 0; gi < N; gi++) begin : g_split
        assign ev_start[gi] = tstartstop_i[2*gi];
        assign ev_stop[gi]  = tstartstop_i[2*gi+1];
    end

    // Round start and table-write qualification; go has priority over a write.
    always_comb begin
        start_round  = (state_q == ST_IDLE) && go_i;
        cfg_accept   = (state_q == ST_IDLE) && !go_i && cfg.cfg_we &&
                       ({1'b0, cfg.cfg_src} < N_EXT);
        cfg_entry_ok = (cfg.cfg_first <= cfg.cfg_last) &&
                       ({1'b0, cfg.cfg_last} < N_EXT);
        deliver_en   = (state_q == ST_DELIVER);
    end

    // Current source's snapshot event and table entry; src_q is stable across
    // its DELIVER cycles, so the net value is simply recomputed each cycle.
    always_comb begin
        cur_start = snap_start_q[src_q];
        cur_stop  = snap_stop_q[src_q];
        cur_valid = tbl_valid_q[src_q];
        cur_bad   = tbl_bad_q[src_q];
        cur_first = tbl_first_q[src_q];
        cur_last  = tbl_last_q[src_q];
        net_nz    = cur_start ^ cur_stop;
        if (!net_nz) begin
            net_val = '0;
        end else if (cur_stop) begin
            net_val = '1;
        end else begin
            net_val = W'(1);
        end
    end

    // Next-state logic: scan one source per cycle, deliver one target per cycle.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        tgt_d   = tgt_q;
        case (state_q)
            ST_IDLE: begin
                if (go_i) begin
                    state_d = ST_SCAN;
                    src_d   = '0;
                end
            end
            ST_SCAN: begin
                if (net_nz && cur_valid) begin
                    tgt_d   = cur_first;
                    state_d = ST_DELIVER;
                end else if (src_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    src_d = src_q + IDX_BITS'(1);
                end
            end
            ST_DELIVER: begin
                if (tgt_q == cur_last) begin
                    if (src_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        src_d   = src_q + IDX_BITS'(1);
                        state_d = ST_SCAN;
                    end
                end else begin
                    tgt_d = tgt_q + IDX_BITS'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and scan/deliver pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            tgt_q   <= tgt_d;
        end
    end

    // Pending capture; a round snapshots pending and restarts it from the
    // pulses of the go cycle so in-round events carry into the next round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_start_q <= '0;
            pend_stop_q  <= '0;
            snap_start_q <= '0;
            snap_stop_q  <= '0;
        end else if (start_round) begin
            snap_start_q <= pend_start_q;
            snap_stop_q  <= pend_stop_q;
            pend_start_q <= ev_start;
            pend_stop_q  <= ev_stop;
        end else begin
            pend_start_q <= pend_start_q | ev_start;
            pend_stop_q  <= pend_stop_q | ev_stop;
        end
    end

    // Connection table entries, one writable slot per source.
    for (genvar gi = 0; gi < N; gi++) begin : g_tbl
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tbl_valid_q[gi] <= 1'b0;
                tbl_bad_q[gi]   <= 1'b0;
                tbl_first_q[gi] <= '0;
                tbl_last_q[gi]  <= '0;
            end else if (cfg_accept && (cfg.cfg_src == IDX_BITS'(gi))) begin
                tbl_valid_q[gi] <= cfg_entry_ok;
                tbl_bad_q[gi]   <= cfg.cfg_bad;
                tbl_first_q[gi] <= cfg.cfg_first;
                tbl_last_q[gi]  <= cfg.cfg_last;
            end
        end
    end

`ifdef TTT_ROUTER_SATURATE_EN
    localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};

    logic [N-1:0] hit_ovf;
    logic         sat_q;
`endif

    // Per-target accumulators: cleared at round start, updated when addressed.
    for (genvar gi = 0; gi < N; gi++) begin : g_acc
        logic hit;
        logic signed [W-1:0] res_good, res_bad;

        assign hit = deliver_en && (tgt_q == IDX_BITS'(gi));

`ifdef TTT_ROUTER_SATURATE_EN
        logic [W:0] sum_good, sum_bad;
        logic       ovf_good, ovf_bad;

        // Add in one extra bit and clamp when the sign bits disagree.
        always_comb begin
            sum_good = {acc_good_q[gi][W-1], acc_good_q[gi]} + {net_val[W-1], net_val};
            sum_bad  = {acc_bad_q[gi][W-1], acc_bad_q[gi]} + {net_val[W-1], net_val};
            ovf_good = sum_good[W] ^ sum_good[W-1];
            ovf_bad  = sum_bad[W] ^ sum_bad[W-1];
            res_good = ovf_good ? (sum_good[W] ? ACC_MIN : ACC_MAX) : sum_good[W-1:0];
            res_bad  = ovf_bad  ? (sum_bad[W]  ? ACC_MIN : ACC_MAX) : sum_bad[W-1:0];
        end

        assign hit_ovf[gi] = hit && (cur_bad ? ovf_bad : ovf_good);
`else
        // Plain two's-complement wrap.
        always_comb begin
            res_good = acc_good_q[gi] + net_val;
            res_bad  = acc_bad_q[gi] + net_val;
        end
`endif

        // Accumulator registers for target gi.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_good_q[gi] <= '0;
                acc_bad_q[gi]  <= '0;
            end else if (start_round) begin
                acc_good_q[gi] <= '0;
                acc_bad_q[gi]  <= '0;
            end else if (hit) begin
                if (cur_bad) begin
                    acc_bad_q[gi] <= res_bad;
                end else begin
                    acc_good_q[gi] <= res_good;
                end
            end
        end

        assign new_good_tokens_o[gi*W +: W] = acc_good_q[gi];
        assign new_bad_tokens_o[gi*W +: W]  = acc_bad_q[gi];
    end

`ifdef TTT_ROUTER_SATURATE_EN
    // Saturation flag: cleared by a new round, set by any clamped add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (start_round) begin
            sat_q <= 1'b0;
        end else if (|hit_ovf) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag_o = sat_q;
`else
    assign sat_flag_o = 1'b0;
`endif

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);

endmodule
